// File: rtl/ex_div_seq_if.sv
// EX-stage <-> divide sequencer connection: op request, retire/flush controls,
// and the status/result returned to EX (plus the sequencer state for observation).
interface ex_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             div_valid;
    logic [1:0]       div_op;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             es_leave;
    logic             flush;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_result;
    logic [1:0]       dbg_state;

    // Handshake: an op is taken on a rising edge where the sequencer is idle,
    // div_valid=1 and flush=0. div_done then stays high with div_result stable
    // until an edge with es_leave=1 (or flush) returns the sequencer to idle.
    modport master (
        output div_valid, div_op, div_src1, div_src2, es_leave, flush,
        input  div_busy, div_done, div_result, dbg_state
    );

    modport slave (
        input  div_valid, div_op, div_src1, div_src2, es_leave, flush,
        output div_busy, div_done, div_result, dbg_state
    );
endinterface

// File: rtl/ex_div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for the EX stage (DIV/MOD[.W/.WU]).
// Optional macro DIV_EARLY_OUT_EN: skip iteration when divisor is 0 or |src1| < |src2|.
module ex_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    ex_div_seq_if.slave   div_if
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic             signed_q, signed_d;
    logic             mod_q, mod_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   rem_shift, trial;
    logic             step_ok;
    logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;

    always_comb begin
        mag1 = (div_if.div_op[1] & div_if.div_src1[WIDTH-1]) ? -div_if.div_src1 : div_if.div_src1;
        mag2 = (div_if.div_op[1] & div_if.div_src2[WIDTH-1]) ? -div_if.div_src2 : div_if.div_src2;

        // One restoring step: the dividend bits shift out of quo_q into the remainder.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr_q};
        step_ok   = ~trial[WIDTH];
        rem_step  = step_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], step_ok};

        q_fix = (signed_q & (s1_q ^ s2_q)) ? -quo_step : quo_step;
        r_fix = (signed_q & s1_q) ? -rem_step : rem_step;
        if (dz_q) begin
            q_fix = '1;
            r_fix = src1_q;
        end

        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        src1_d   = src1_q;
        signed_d = signed_q;
        mod_d    = mod_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (div_if.div_valid) begin
                    state_d  = S_CALC;
                    busy_d   = 1'b1;
                    count_d  = '0;
                    rem_d    = '0;
                    quo_d    = mag1;
                    dvsr_d   = mag2;
                    src1_d   = div_if.div_src1;
                    signed_d = div_if.div_op[1];
                    mod_d    = div_if.div_op[0];
                    s1_d     = div_if.div_op[1] & div_if.div_src1[WIDTH-1];
                    s2_d     = div_if.div_op[1] & div_if.div_src2[WIDTH-1];
                    dz_d     = (div_if.div_src2 == '0);
`ifdef DIV_EARLY_OUT_EN
                    if ((div_if.div_src2 == '0) || (mag1 < mag2)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        if (div_if.div_op[0]) begin
                            result_d = div_if.div_src1;
                        end else begin
                            result_d = (div_if.div_src2 == '0) ? '1 : '0;
                        end
                    end
`endif
                end
            end
            S_CALC: begin
                count_d = count_q + 1'b1;
                rem_d   = rem_step;
                quo_d   = quo_step;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = mod_q ? r_fix : q_fix;
                end
            end
            S_DONE: begin
                if (div_if.es_leave) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Flush overrides everything, including an accept in the same cycle.
        if (div_if.flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            src1_q   <= '0;
            signed_q <= 1'b0;
            mod_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            src1_q   <= src1_d;
            signed_q <= signed_d;
            mod_q    <= mod_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign div_if.div_busy   = busy_q;
    assign div_if.div_done   = done_q;
    assign div_if.div_result = result_q;
    assign div_if.dbg_state  = state_q;
endmodule
